bit_serial_subtractor: RTL and testbench
========================================

BIT_SERIAL_SUBTRACTOR -- requirements
Module: bit_serial_subtractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, meaning operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL change on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset; reset SHALL be asynchronous and active-high.
REQ-004 The block SHALL have port start_valid, input, 1 bit, meaning the requester offers an operand pair.
REQ-005 The block SHALL have port start_ready, output, 1 bit, meaning the block can accept an operand pair.
REQ-006 The block SHALL have port a_in, input, WIDTH bits, the minuend, sampled on start handshake.
REQ-007 The block SHALL have port b_in, input, WIDTH bits, the subtrahend, sampled on start handshake.
REQ-008 The block SHALL have port diff_out, output, WIDTH bits, the result (a_in - b_in) mod 2^WIDTH.
REQ-009 The block SHALL have port borrow_out, output, 1 bit, meaning the final borrow (1 iff a_in < b_in, unsigned).
REQ-010 The block SHALL have port done_valid, output, 1 bit, meaning diff_out and borrow_out are valid.
REQ-011 The block SHALL have port done_ready, input, 1 bit, meaning the consumer accepts the result.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 In IDLE, start_ready SHALL be 1; start_ready SHALL be 0 in RUN and in DONE.
REQ-014 The start handshake SHALL be start_valid && start_ready at a clock edge; on that edge: load a_in/b_in into shift registers, clear borrow flop, clear bit counter, clear result register, go to RUN.
REQ-015 start_valid outside IDLE SHALL be ignored; no operands are latched.
REQ-016 Each RUN cycle SHALL process exactly one bit, LSB first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-017 Each RUN cycle SHALL shift the operand registers right by one and shift d into the result register MSB, so the result is correctly aligned after WIDTH shifts.
REQ-018 In RUN, the counter SHALL increment each cycle; on the cycle with counter == WIDTH-1, the FSM SHALL go to DONE.
REQ-019 Latency: done_valid SHALL first be 1 exactly WIDTH clock edges after the start-handshake edge.
REQ-020 In DONE, done_valid SHALL be 1, and diff_out and borrow_out SHALL hold stable for as long as done_ready is 0 (backpressure has no limit).
REQ-021 On an edge with done_valid && done_ready, the FSM SHALL go to IDLE; diff_out/borrow_out SHALL retain the last result until the next start handshake.
REQ-022 A new start SHALL NOT be accepted in the same cycle as result acceptance; the earliest next start is the cycle after.
REQ-023 done_valid SHALL be 0 in IDLE and RUN.
REQ-024 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap during RUN.

Reset
REQ-025 Asserting rst SHALL asynchronously force: state = IDLE, start_ready = 1, done_valid = 0, diff_out = 0, borrow_out = 0, counter = 0, and all shift registers = 0.
REQ-026 Reset mid-RUN or mid-DONE SHALL abandon the operation with no output pulse; after rst deasserts, the first edge with start_valid = 1 SHALL be accepted.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-028 A combinational sub-module full_subtractor (inputs a, b, bin; outputs d, bout) SHALL implement REQ-016 and be instantiated once.
REQ-029 The datapath SHALL contain a single bit-slice; there SHALL be no parallel WIDTH-bit subtractor.

Verification
REQ-030 The bench SHALL cover basic subtraction: WIDTH = 8, a = 100, b = 37 -> after 8 cycles, done_valid = 1, diff_out = 63, borrow_out = 0.
REQ-031 The bench SHALL cover underflow: a = 5, b = 10 -> diff_out = 251 (0xFB), borrow_out = 1.
REQ-032 The bench SHALL cover edge values: 0 - 0 -> 0, borrow 0; 0xFF - 0xFF -> 0, borrow 0; 0x00 - 0x01 -> 0xFF, borrow 1.
REQ-033 The bench SHALL cover backpressure: done_ready held 0 for 5 cycles after done_valid -> outputs stable and start_ready = 0; done_ready = 1 -> start_ready = 1 on the next cycle.
REQ-034 The bench SHALL cover start_valid during RUN: pulse start_valid with a = 1, b = 1 while RUN -> ignored; the original result is still produced.
REQ-035 The bench SHALL cover reset mid-RUN: assert rst at bit 3 -> done_valid = 0 and start_ready = 1 immediately; next operation 200 - 100 -> 100, borrow 0.

Source files
------------

// File: rtl/bit_serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding, the default operand width and the counter sizing helper.
package bit_serial_subtractor_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width: ceil(log2(width)), never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        int unsigned w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with the borrow out in bout.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: computes (a_in - b_in) mod 2^WIDTH one bit per clock, LSB first,
// using a single full-subtractor slice. It takes a start handshake in and returns a done handshake.
module bit_serial_subtractor
    import bit_serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
    output logic             done_valid,
    input  logic             done_ready
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [CNT_W-1:0]   cnt;
    logic               last_bit;
    logic               load;
    logic               shift;
    logic               start_ready_next;
    logic               done_valid_next;
    logic               bit_d;
    logic               bit_bout;

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // The single bit-slice. borrow_out doubles as the running borrow flop.
    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow_out),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_valid && start_ready) state_next = RUN;
            RUN:  if (last_bit)                   state_next = DONE;
            DONE: if (done_ready)                 state_next = IDLE;
            default:                              state_next = IDLE;
        endcase
    end

    // Output and datapath-control decode; the handshake flags are registered against next state
    always_comb begin
        load             = 1'b0;
        shift            = 1'b0;
        start_ready_next = (state_next == IDLE);
        done_valid_next  = (state_next == DONE);
        case (state)
            IDLE:    load  = start_valid && start_ready;
            RUN:     shift = 1'b1;
            default: ;
        endcase
    end

    // Handshake flags and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_ready <= 1'b1;
            done_valid  <= 1'b0;
            a_sh        <= '0;
            b_sh        <= '0;
            cnt         <= '0;
            diff_out    <= '0;
            borrow_out  <= 1'b0;
        end else begin
            start_ready <= start_ready_next;
            done_valid  <= done_valid_next;
            if (load) begin
                a_sh       <= a_in;
                b_sh       <= b_in;
                cnt        <= '0;
                diff_out   <= '0;
                borrow_out <= 1'b0;
            end else if (shift) begin
                a_sh       <= {1'b0, a_sh[WIDTH-1:1]};
                b_sh       <= {1'b0, b_sh[WIDTH-1:1]};
                diff_out   <= {bit_d, diff_out[WIDTH-1:1]};
                borrow_out <= bit_bout;
                // Hold on the last bit so the counter never wraps
                if (!last_bit) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed self-checking bench for bit_serial_subtractor at WIDTH = 8.
module tb_bit_serial_subtractor;

    localparam int unsigned WIDTH = 8;
    localparam int          MAX_WAIT = 64;

    logic             clk;
    logic             rst;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] diff_out;
    logic             borrow_out;
    logic             done_valid;
    logic             done_ready;

    int checks;
    int errors;

    bit_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .diff_out    (diff_out),
        .borrow_out  (borrow_out),
        .done_valid  (done_valid),
        .done_ready  (done_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand pair; assumes the block is idle.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start_valid = 1'b1;
        a_in        = a;
        b_in        = b;
        tick();
        start_valid = 1'b0;
        a_in        = '0;
        b_in        = '0;
    endtask

    // Count edges from the handshake edge until done_valid, bounded.
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done_valid && n < MAX_WAIT) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(WIDTH));
    endtask

    task automatic accept(input string tag, input logic [WIDTH-1:0] exp_d, input logic exp_b);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check({tag, "_ready_after"}, 32'(start_ready), 32'd1);
        check({tag, "_valid_after"}, 32'(done_valid), 32'd0);
        check({tag, "_diff_kept"},   32'(diff_out), 32'(exp_d));
        check({tag, "_borrow_kept"}, 32'(borrow_out), 32'(exp_b));
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_d, input logic exp_b);
        start_op(a, b);
        check({tag, "_busy"}, 32'(start_ready), 32'd0);
        wait_done(tag);
        check({tag, "_diff"},   32'(diff_out), 32'(exp_d));
        check({tag, "_borrow"}, 32'(borrow_out), 32'(exp_b));
        accept(tag, exp_d, exp_b);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        start_valid = 1'b0;
        done_ready  = 1'b0;
        a_in        = '0;
        b_in        = '0;
        #12;
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_done_valid",  32'(done_valid), 32'd0);
        check("rst_diff",        32'(diff_out), 32'd0);
        check("rst_borrow",      32'(borrow_out), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Basic, underflow and edge values
        run_op("basic",   8'd100, 8'd37,  8'd63,  1'b0);
        run_op("under",   8'd5,   8'd10,  8'hFB,  1'b1);
        run_op("zero",    8'h00,  8'h00,  8'h00,  1'b0);
        run_op("ff_ff",   8'hFF,  8'hFF,  8'h00,  1'b0);
        run_op("z_min1",  8'h00,  8'h01,  8'hFF,  1'b1);
        run_op("msb_lo",  8'h80,  8'h7F,  8'h01,  1'b0);
        run_op("msb_hi",  8'h7F,  8'h80,  8'hFF,  1'b1);

        // Backpressure: 90 - 60 = 30 held for five cycles
        start_op(8'd90, 8'd60);
        wait_done("bp");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid_hold",  32'(done_valid), 32'd1);
            check("bp_diff_hold",   32'(diff_out), 32'd30);
            check("bp_borrow_hold", 32'(borrow_out), 32'd0);
            check("bp_ready_low",   32'(start_ready), 32'd0);
        end
        // A start offered on the acceptance edge must not be taken until the next cycle
        start_valid = 1'b1;
        a_in        = 8'd7;
        b_in        = 8'd3;
        done_ready  = 1'b1;
        tick();
        done_ready = 1'b0;
        check("bp_ready_after", 32'(start_ready), 32'd1);
        check("bp_valid_after", 32'(done_valid), 32'd0);
        check("bp_diff_kept",   32'(diff_out), 32'd30);
        tick();
        start_valid = 1'b0;
        check("next_busy", 32'(start_ready), 32'd0);
        wait_done("next");
        check("next_diff",   32'(diff_out), 32'd4);
        check("next_borrow", 32'(borrow_out), 32'd0);
        accept("next", 8'd4, 1'b0);

        // start_valid during RUN is ignored: 200 - 13 = 187
        start_op(8'd200, 8'd13);
        tick();
        tick();
        start_valid = 1'b1;
        a_in        = 8'd1;
        b_in        = 8'd1;
        tick();
        start_valid = 1'b0;
        check("ign_ready", 32'(start_ready), 32'd0);
        begin : ign_wait
            int n;
            n = 3;
            while (!done_valid && n < MAX_WAIT) begin
                tick();
                n++;
            end
            check("ign_latency", 32'(n), 32'(WIDTH));
        end
        check("ign_diff",   32'(diff_out), 32'd187);
        check("ign_borrow", 32'(borrow_out), 32'd0);
        accept("ign", 8'd187, 1'b0);

        // Reset mid-RUN at bit 3
        start_op(8'h12, 8'h34);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(done_valid), 32'd0);
        check("mid_rst_ready", 32'(start_ready), 32'd1);
        check("mid_rst_diff",  32'(diff_out), 32'd0);
        tick();
        rst = 1'b0;
        begin : no_pulse
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 12; i++) begin
                tick();
                seen = seen | done_valid;
            end
            check("mid_rst_no_pulse", 32'(seen), 32'd0);
        end
        run_op("post_rst", 8'd200, 8'd100, 8'd100, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
